fifo_uart_tx: RTL and testbench

Downstream drain stage for the synchronous FIFO. It pops one word whenever the FIFO is non-empty and transmission is enabled, then serialises it as an asynchronous UART frame: start bit, data LSB-first, optional parity, stop bit(s). The FIFO read port is combinational: read data is valid in the same cycle `r_en` is high and the FIFO is not empty. This block consumes the word on that same clock edge.

---
 rtl/uart_tx_pkg.sv | 14 +
 rtl/uart_bit_timer.sv | 34 +++
 rtl/fifo_uart_tx.sv | 131 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types for the FIFO-draining UART transmitter
package uart_tx_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  localparam int FRAMES_CNT_W = 16;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period timer; tick marks the last clk of each serial bit
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] clk_cnt_q;
  logic [CW-1:0] clk_cnt_d;

  always_comb begin
    clk_cnt_d = clk_cnt_q + 1'b1;
    if (clear || (clk_cnt_q == LAST)) begin
      clk_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt_q <= '0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
    end
  end

  assign tick = ~clear & (clk_cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops words from a show-ahead FIFO and serialises them as UART frames
module fifo_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tx_en,
  input  logic                    fifo_empty,
  input  logic [DATA_WIDTH-1:0]   fifo_r_data,
  output logic                    fifo_r_en,
  output logic                    tx,
  output logic                    busy,
  output logic                    frame_done,
  output logic [FRAMES_CNT_W-1:0] frames_sent
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int SW = $clog2(2 * CLKS_PER_BIT + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS * CLKS_PER_BIT - 1);

  tx_state_e               state_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [BW-1:0]           bit_cnt_q;
  logic [SW-1:0]           stop_cnt_q;
  logic                    parity_q;
  logic                    tx_q;
  logic                    busy_q;
  logic                    done_q;
  logic [FRAMES_CNT_W-1:0] frames_q;
  logic                    pop;
  logic                    timer_clear;
  logic                    bit_tick;

  // The word is taken from the combinational read port on the same edge as the strobe.
  assign pop         = (state_q == TX_IDLE) & tx_en & ~fifo_empty & ~rst;
  assign timer_clear = (state_q == TX_IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .tick (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      frames_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        TX_IDLE: begin
          if (pop) begin
            shift_q    <= fifo_r_data;
            parity_q   <= (^fifo_r_data) ^ PARITY_ODD[0];
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            state_q    <= TX_START;
          end
        end
        TX_START: begin
          if (bit_tick) begin
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (bit_tick) begin
            if (bit_cnt_q == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                tx_q    <= parity_q;
                state_q <= TX_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= TX_STOP;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end
        end
        TX_PARITY: begin
          if (bit_tick) begin
            tx_q    <= 1'b1;
            state_q <= TX_STOP;
          end
        end
        TX_STOP: begin
          // Stop phase is timed in raw clocks so two stop bits need no extra bit bookkeeping.
          if (stop_cnt_q == STOP_LAST) begin
            state_q  <= TX_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            frames_q <= frames_q + 1'b1;
          end else begin
            stop_cnt_q <= stop_cnt_q + 1'b1;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign fifo_r_en   = pop;
  assign tx          = tx_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - bench for fifo_uart_tx: frame-level reference model plus directed vectors
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int DW  = 8;

  logic        clk;
  logic        rst;
  logic        tx_en;
  logic        fe [3];
  logic [7:0]  fd [3];
  logic        re_w [3];
  logic        tx_w [3];
  logic        busy_w [3];
  logic        done_w [3];
  logic [15:0] fs_w [3];

  int tests;
  int fails;
  int cyc;

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fe[0]), .fifo_r_data(fd[0]),
    .fifo_r_en(re_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]), .frames_sent(fs_w[0]));
  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fe[1]), .fifo_r_data(fd[1]),
    .fifo_r_en(re_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]), .frames_sent(fs_w[1]));
  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fe[2]), .fifo_r_data(fd[2]),
    .fifo_r_en(re_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]), .frames_sent(fs_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  function automatic int q_size(int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [7:0] q_front(int k);
    case (k)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic void q_pop(int k);
    case (k)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endfunction

  function automatic void q_push(int k, logic [7:0] v);
    case (k)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic int pen(int k);
    return (k != 0) ? 1 : 0;
  endfunction

  function automatic int flen(int k);
    return (1 + DW + pen(k) + 1) * CPB;
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // FIFO contents as seen by the DUT's read port, refreshed just after each edge
  initial begin
    for (int k = 0; k < 3; k++) begin
      fe[k] = 1'b1;
      fd[k] = 8'h00;
    end
  end

  always @(posedge clk) begin
    #2;
    for (int k = 0; k < 3; k++) begin
      fe[k] = (q_size(k) == 0);
      fd[k] = (q_size(k) != 0) ? q_front(k) : 8'h00;
    end
  end

  // Reference model: pos = clocks into the current frame (0 = line idle)
  int         pos [3];
  int         mcnt [3];
  bit         mdone [3];
  logic [7:0] mdata [3];
  bit         mvalid;
  bit         exp_re [3];

  function automatic logic exp_line(int k, int p);
    int b;
    b = (p - 1) / CPB;
    if (b == 0) return 1'b0;
    if (b <= DW) return mdata[k][b-1];
    if (pen(k) != 0 && b == DW + 1) return (^mdata[k]) ^ (k == 2);
    return 1'b1;
  endfunction

  initial begin
    mvalid = 1'b0;
    cyc = 0;
    for (int k = 0; k < 3; k++) begin
      pos[k] = 0; mcnt[k] = 0; mdone[k] = 1'b0; mdata[k] = 8'h00;
    end
  end

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      logic [19:0] act;
      logic [19:0] exp;
      exp_re[k] = (pos[k] == 0) && tx_en && !fe[k] && !rst;
      if (mvalid) begin
        act = {fs_w[k], re_w[k], tx_w[k], busy_w[k], done_w[k]};
        exp = {mcnt[k][15:0], exp_re[k], (pos[k] == 0) ? 1'b1 : exp_line(k, pos[k]), pos[k] != 0, mdone[k]};
        check(act === exp, $sformatf("model_dut%0d {fs,r_en,tx,busy,done}", k), 32'(act), 32'(exp));
      end else begin
        check(re_w[k] === exp_re[k], $sformatf("model_dut%0d r_en", k), 32'(re_w[k]), 32'(exp_re[k]));
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        pos[k] = 0; mdone[k] = 1'b0; mcnt[k] = 0;
      end else begin
        mdone[k] = 1'b0;
        if (pos[k] == flen(k)) begin
          pos[k] = 0; mdone[k] = 1'b1; mcnt[k] = (mcnt[k] + 1) & 16'hFFFF;
        end else if (pos[k] > 0) begin
          pos[k]++;
        end else if (exp_re[k]) begin
          mdata[k] = q_front(k); q_pop(k); pos[k] = 1;
        end
      end
    end
    if (rst) mvalid = 1'b1;
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((pos[0] != 0 || pos[1] != 0 || pos[2] != 0 || q_size(0) != 0 || q_size(1) != 0 || q_size(2) != 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(n < 600, "idle_timeout", 32'(n), 32'd600);
    @(negedge clk);
  endtask

  task automatic wait_pop(input int k, input string name);
    int n;
    n = 0;
    while (!re_w[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(n < 100, name, 32'(n), 32'd100);
  endtask

  typedef struct {
    int          k;
    logic [7:0]  data;
    logic [10:0] bits;
    int          done_cyc;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int          pops;
    int          last_pop;
    int          base_cnt;
    int          done_at;
    int          done_n;
    logic [10:0] got;

    vecs[0] = '{k: 0, data: 8'hA5, bits: 11'b11101001010, done_cyc: 41};
    vecs[1] = '{k: 1, data: 8'h07, bits: 11'b11000001110, done_cyc: 45};
    vecs[2] = '{k: 2, data: 8'h07, bits: 11'b10000001110, done_cyc: 45};
    vecs[3] = '{k: 2, data: 8'h00, bits: 11'b11000000000, done_cyc: 45};
    vecs[4] = '{k: 1, data: 8'hFF, bits: 11'b10111111110, done_cyc: 45};
    vecs[5] = '{k: 0, data: 8'h3C, bits: 11'b11001111000, done_cyc: 41};
    tests = 0;
    fails = 0;

    // Reset held three cycles with data waiting and transmit enabled
    rst = 1'b1;
    tx_en = 1'b1;
    q_push(0, 8'h3C);
    repeat (3) begin
      @(negedge clk);
      check(re_w[0] === 1'b0, "reset_r_en", 32'(re_w[0]), 32'd0);
    end
    check(tx_w[0] === 1'b1 && busy_w[0] === 1'b0 && fs_w[0] === 16'd0, "reset_outputs",
          {tx_w[0], busy_w[0], fs_w[0]}, 32'h0002_0000);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_idle();

    // Per-vector frame waveform, parity and completion timing
    for (int v = 0; v < 6; v++) begin
      @(posedge clk); #1;
      q_push(vecs[v].k, vecs[v].data);
      @(negedge clk);
      wait_pop(vecs[v].k, "vec_pop_timeout");
      done_at = 0;
      done_n = 0;
      got = '0;
      for (int c = 1; c <= 50; c++) begin
        @(negedge clk);
        if (c >= 2 && ((c - 2) % CPB) == 0 && ((c - 2) / CPB) <= 10) got[(c - 2) / CPB] = tx_w[vecs[v].k];
        if (done_w[vecs[v].k] === 1'b1) begin
          done_n++;
          if (done_at == 0) done_at = c;
        end
      end
      check(got === vecs[v].bits, $sformatf("vec%0d_bits", v), 32'(got), 32'(vecs[v].bits));
      check(done_at == vecs[v].done_cyc && done_n == 1, $sformatf("vec%0d_done_cycle", v),
            32'(done_at * 16 + done_n), 32'(vecs[v].done_cyc * 16 + 1));
      wait_idle();
    end

    // Back-to-back: three queued words, pops F+1 apart
    base_cnt = mcnt[0];
    @(posedge clk); #1;
    q_push(0, 8'h01); q_push(0, 8'h02); q_push(0, 8'h03);
    pops = 0;
    last_pop = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (re_w[0] === 1'b1) begin
        if (pops > 0) check(cyc - last_pop == 41, "b2b_spacing", 32'(cyc - last_pop), 32'd41);
        pops++;
        last_pop = cyc;
      end
    end
    check(pops == 3, "b2b_pop_count", 32'(pops), 32'd3);
    check(fs_w[0] === 16'((base_cnt + 3) & 16'hFFFF) && tx_w[0] === 1'b1, "b2b_frames_sent",
          {tx_w[0], fs_w[0]}, {1'b1, 16'((base_cnt + 3) & 16'hFFFF)});

    // tx_en dropped during the first of two queued words
    @(posedge clk); #1;
    q_push(0, 8'h11); q_push(0, 8'h22);
    @(negedge clk);
    wait_pop(0, "txen_first_pop");
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    tx_en = 1'b0;
    done_n = 0;
    for (int c = 0; c < 60 && done_n == 0; c++) begin
      @(negedge clk);
      if (done_w[0] === 1'b1) done_n++;
    end
    check(done_n == 1, "txen_first_done", 32'(done_n), 32'd1);
    pops = 0;
    repeat (20) begin
      @(negedge clk);
      if (re_w[0] === 1'b1) pops++;
    end
    check(pops == 0, "txen_no_pop", 32'(pops), 32'd0);
    @(posedge clk); #1;
    tx_en = 1'b1;
    @(negedge clk);
    check(re_w[0] === 1'b1, "txen_resume_pop", 32'(re_w[0]), 32'd1);
    wait_idle();

    // Reset pulse mid-DATA aborts the frame
    @(posedge clk); #1;
    q_push(0, 8'h5A);
    @(negedge clk);
    wait_pop(0, "rst_first_pop");
    repeat (12) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check(tx_w[0] === 1'b1 && busy_w[0] === 1'b0 && fs_w[0] === 16'd0 && done_w[0] === 1'b0, "rst_abort",
          {tx_w[0], busy_w[0], done_w[0], fs_w[0]}, 32'h0004_0000);
    repeat (40) begin
      @(negedge clk);
      check(done_w[0] === 1'b0, "rst_no_done", 32'(done_w[0]), 32'd0);
    end
    @(posedge clk); #1;
    q_push(0, 8'h66);
    @(negedge clk);
    wait_pop(0, "rst_new_pop");
    wait_idle();

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        int k;
        k = $urandom_range(0, 2);
        if (q_size(k) < 4) q_push(k, 8'($urandom));
      end
      if ($urandom_range(0, 49) == 0) tx_en = ~tx_en;
      if ($urandom_range(0, 399) == 0) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tx_en = 1'b1;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected below 200000", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
